// File: rtl/sort_ctrl_pkg.sv
// sort_ctrl_pkg: shared state encoding and constants for the insertion-sort stream controller
package sort_ctrl_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int POS_W_DEF  = 8;
   localparam int N_DEF      = 16;
   localparam int CLR_CYCLES = 2;
   localparam logic [DATA_W_DEF-1:0] SENTINEL = '1;
   typedef enum logic [2:0] {CLEAR, FILL, F_CALL, DRAIN, D_CALL, HOLD} sort_state_e;
endpackage

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: feeds a frame of samples into the HLS insertion sorter and streams the sorted frame out
module sort_stream_ctrl
   import sort_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int POS_W  = POS_W_DEF,
   parameter int N      = N_DEF
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              srt_rst,
   output logic              srt_start,
   input  logic              srt_done,
   input  logic              srt_idle,
   input  logic              srt_ready,
   output logic [DATA_W-1:0] srt_data,
   output logic [POS_W-1:0]  srt_pos,
   input  logic [DATA_W-1:0] srt_ret,
   output logic              frame_done
);
   localparam logic [POS_W-1:0] LAST = POS_W'(N - 1);
   sort_state_e      state;
   logic [POS_W-1:0] in_cnt;
   logic [POS_W-1:0] pos_cnt;
   logic [1:0]       clr_cnt;
   logic             out_take;
   assign out_take   = out_valid && out_ready;
   assign in_ready   = (state == FILL) && srt_idle;
   assign frame_done = (state == HOLD) && out_take && out_last;
   // frame sequencer, sorter handshakes and the single-entry output register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= CLEAR;
         srt_rst   <= 1'b1;
         srt_start <= 1'b0;
         srt_data  <= '0;
         srt_pos   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         in_cnt    <= '0;
         pos_cnt   <= '0;
         clr_cnt   <= '0;
      end else begin
         if (out_take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (state)
            CLEAR: begin
               in_cnt  <= '0;
               pos_cnt <= '0;
               if (clr_cnt == 2'(CLR_CYCLES - 1)) begin
                  clr_cnt <= '0;
                  srt_rst <= 1'b0;
                  state   <= FILL;
               end else begin
                  clr_cnt <= clr_cnt + 2'd1;
               end
            end
            FILL: if (in_valid && in_ready) begin
               srt_data  <= in_data;
               srt_pos   <= '0;
               srt_start <= 1'b1;
               state     <= F_CALL;
            end
            F_CALL: begin
               if (srt_ready || srt_done) srt_start <= 1'b0;
               if (srt_done) begin
                  in_cnt <= in_cnt + 1'b1;
                  state  <= (in_cnt == LAST) ? DRAIN : FILL;
               end
            end
            DRAIN: if (!out_valid || out_ready) begin
               srt_data  <= '1;
               srt_pos   <= pos_cnt;
               srt_start <= 1'b1;
               state     <= D_CALL;
            end
            D_CALL: begin
               if (srt_ready || srt_done) srt_start <= 1'b0;
               if (srt_done) begin
                  out_data  <= srt_ret;
                  out_valid <= 1'b1;
                  out_last  <= (pos_cnt == LAST);
                  pos_cnt   <= pos_cnt + 1'b1;
                  state     <= (pos_cnt == LAST) ? HOLD : DRAIN;
               end
            end
            HOLD: if (out_take) begin
               srt_rst <= 1'b1;
               state   <= CLEAR;
            end
            default: state <= CLEAR;
         endcase
      end
   end
endmodule
